// File: rtl/qd_arb.sv
// Two-requester round-robin front end for a shared combinational qd classifier.
// One request is in flight at a time: IDLE accepts, EVAL samples the classifier, RESP holds the result.
`timescale 1ns/1ps

module qd_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_data,
  output logic             req1_ready,
  output logic [3:0]       qd_a,
  input  logic             qd_p,
  input  logic             qd_d,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_p,
  output logic             rsp_d,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_p,
  output logic [CNT_W-1:0] cnt_d
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       qd_a_q, qd_a_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_p_q, rsp_p_d;
  logic             rsp_d_q, rsp_d_d;
  logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
  logic [CNT_W-1:0] cnt_d_q, cnt_d_d;

  logic             grant_any_s;
  logic             grant_idx_s;
  logic [3:0]       grant_data_s;
  logic             xfer_s;
  logic             inc_p_s;
  logic             inc_d_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
    logic [CNT_W-1:0] res;
    if (!en) begin
      res = val;
    end else if (val == CNT_MAX) begin
      res = val;
    end else begin
      res = val + CNT_ONE;
    end
    return res;
  endfunction

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant_any_s  = req0_valid | req1_valid;
    grant_idx_s  = 1'b0;
    grant_data_s = 4'h0;
    if (req0_valid && req1_valid) begin
      grant_idx_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_idx_s = 1'b1;
    end else begin
      grant_idx_s = 1'b0;
    end
    if (grant_idx_s) begin
      grant_data_s = req1_data;
    end else begin
      grant_data_s = req0_data;
    end
  end

  // Ready is forced low while reset is held so nothing appears accepted.
  assign xfer_s     = rst_n && (state_q == ST_IDLE) && grant_any_s;
  assign req0_ready = xfer_s & ~grant_idx_s;
  assign req1_ready = xfer_s &  grant_idx_s;

  // Next-state and datapath updates for the request/evaluate/respond cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    qd_a_d       = qd_a_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_p_d      = rsp_p_q;
    rsp_d_d      = rsp_d_q;
    inc_p_s      = 1'b0;
    inc_d_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          state_d      = ST_EVAL;
          qd_a_d       = grant_data_s;
          rsp_id_d     = grant_idx_s;
          last_grant_d = grant_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EVAL: begin
        rsp_p_d     = qd_p;
        rsp_d_d     = qd_d;
        rsp_valid_d = 1'b1;
        inc_p_s     = qd_p;
        inc_d_s     = qd_d;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // A clear wins over an increment landing on the same edge.
    if (clr_cnt) begin
      cnt_p_d = CNT_ZERO;
      cnt_d_d = CNT_ZERO;
    end else begin
      cnt_p_d = sat_inc(cnt_p_q, inc_p_s);
      cnt_d_d = sat_inc(cnt_d_q, inc_d_s);
    end
  end

  // State registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      qd_a_q       <= 4'h0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_p_q      <= 1'b0;
      rsp_d_q      <= 1'b0;
      cnt_p_q      <= CNT_ZERO;
      cnt_d_q      <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      qd_a_q       <= qd_a_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_p_q      <= rsp_p_d;
      rsp_d_q      <= rsp_d_d;
      cnt_p_q      <= cnt_p_d;
      cnt_d_q      <= cnt_d_d;
    end
  end

  assign qd_a      = qd_a_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_d     = rsp_d_q;
  assign cnt_p     = cnt_p_q;
  assign cnt_d     = cnt_d_q;

endmodule

// File: tb/tb_qd_arb.sv
// Bench for qd_arb: a transaction-level model is compared every cycle against
// two instances (default and 2-bit counters), plus directed literal checks.
`timescale 1ns/1ps

module tb_qd_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0, clr_cnt = 1'b0;
  logic [3:0] req0_data = 4'h0, req1_data = 4'h0;

  // Stand-in classifier: bit k of each table is the result for code k.
  logic [15:0] p_tab = 16'h2CAC;
  logic [15:0] d_tab = 16'h1524;

  logic       r0r_a, r1r_a, qd_p_a, qd_d_a, rv_a, rid_a, rp_a, rd_a;
  logic [3:0] qd_a_a;
  logic [7:0] cp_a, cd_a;
  logic       r0r_b, r1r_b, qd_p_b, qd_d_b, rv_b, rid_b, rp_b, rd_b;
  logic [3:0] qd_a_b;
  logic [1:0] cp_b, cd_b;

  assign qd_p_a = p_tab[qd_a_a];
  assign qd_d_a = d_tab[qd_a_a];
  assign qd_p_b = p_tab[qd_a_b];
  assign qd_d_b = d_tab[qd_a_b];

  qd_arb u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0r_a),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1r_a),
    .qd_a(qd_a_a), .qd_p(qd_p_a), .qd_d(qd_d_a),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_id(rid_a), .rsp_p(rp_a), .rsp_d(rd_a),
    .clr_cnt(clr_cnt), .cnt_p(cp_a), .cnt_d(cd_a)
  );

  qd_arb #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0r_b),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1r_b),
    .qd_a(qd_a_b), .qd_p(qd_p_b), .qd_d(qd_d_b),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_id(rid_b), .rsp_p(rp_b), .rsp_d(rd_b),
    .clr_cnt(clr_cnt), .cnt_p(cp_b), .cnt_d(cd_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one optional in-flight request, one optional held response.
  bit         m_init = 1'b0;
  bit         m_inflight, m_rsp, m_id, m_p, m_d, m_last;
  logic [3:0] m_qd_a;
  int         m_cp8, m_cd8, m_cp2, m_cd2;

  function automatic bit pick(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  function automatic int sat(input int v, input int inc, input int maxv);
    return (v + inc > maxv) ? maxv : v + inc;
  endfunction

  always @(posedge clk) begin : model
    int ip, id;
    bit g;
    ip = 0;
    id = 0;
    if (!rst_n) begin
      m_init = 1'b1; m_inflight = 1'b0; m_rsp = 1'b0;
      m_id = 1'b0; m_p = 1'b0; m_d = 1'b0; m_last = 1'b1; m_qd_a = 4'h0;
      m_cp8 = 0; m_cd8 = 0; m_cp2 = 0; m_cd2 = 0;
    end else if (m_init) begin
      if (m_rsp) begin
        if (rsp_ready) m_rsp = 1'b0;
      end else if (m_inflight) begin
        m_inflight = 1'b0;
        m_rsp = 1'b1;
        m_p = p_tab[m_qd_a];
        m_d = d_tab[m_qd_a];
        ip = m_p ? 1 : 0;
        id = m_d ? 1 : 0;
      end else if (req0_valid || req1_valid) begin
        g = pick(req0_valid, req1_valid, m_last);
        m_inflight = 1'b1;
        m_id = g;
        m_last = g;
        m_qd_a = g ? req1_data : req0_data;
      end
      if (clr_cnt) begin
        m_cp8 = 0; m_cd8 = 0; m_cp2 = 0; m_cd2 = 0;
      end else begin
        m_cp8 = sat(m_cp8, ip, 255); m_cd8 = sat(m_cd8, id, 255);
        m_cp2 = sat(m_cp2, ip, 3);   m_cd2 = sat(m_cd2, id, 3);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit g, e0, e1, idle;
    if (m_init) begin
      idle = !m_inflight && !m_rsp && (req0_valid || req1_valid) && rst_n;
      g  = pick(req0_valid, req1_valid, m_last);
      e0 = idle && !g;
      e1 = idle && g;
      chk("m_req0_ready", r0r_a, e0);
      chk("m_req1_ready", r1r_a, e1);
      chk("m_qd_a", qd_a_a, m_qd_a);
      chk("m_rsp_valid", rv_a, m_rsp);
      chk("m_rsp_id", rid_a, m_id);
      chk("m_rsp_p", rp_a, m_p);
      chk("m_rsp_d", rd_a, m_d);
      chk("m_cnt_p", cp_a, m_cp8);
      chk("m_cnt_d", cd_a, m_cd8);
      chk("m_b_req0_ready", r0r_b, e0);
      chk("m_b_req1_ready", r1r_b, e1);
      chk("m_b_rsp_valid", rv_b, m_rsp);
      chk("m_b_cnt_p", cp_b, m_cp2);
      chk("m_b_cnt_d", cd_b, m_cd2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; clr_cnt = 1'b0; rsp_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int g_idx[8];
  int g_cyc[8];
  int r_id[8];
  int r_p[8];
  int r_d[8];
  int ng, nr;
  bit found;

  initial begin
    // Reset state and single request on requester 0.
    do_reset();
    @(negedge clk);
    chk("rst_rsp_valid", rv_a, 1'b0);
    chk("rst_qd_a", qd_a_a, 4'h0);
    chk("rst_cnt_p", cp_a, 8'd0);
    step();
    rsp_ready = 1'b1; req0_valid = 1'b1; req0_data = 4'h5;
    @(negedge clk);
    chk("s1_ready0", r0r_a, 1'b1);
    chk("s1_ready1", r1r_a, 1'b0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("s1_qd_a", qd_a_a, 4'h5);
    chk("s1_not_yet_valid", rv_a, 1'b0);
    step();
    @(negedge clk);
    chk("s1_rsp_valid", rv_a, 1'b1);
    chk("s1_rsp_id", rid_a, 1'b0);
    chk("s1_rsp_p", rp_a, 1'b1);
    chk("s1_rsp_d", rd_a, 1'b1);
    chk("s1_cnt_p", cp_a, 8'd1);
    chk("s1_cnt_d", cd_a, 8'd1);
    step();
    @(negedge clk);
    chk("s1_retired", rv_a, 1'b0);
    step();

    // Continuous contention: grants alternate, one transfer every 3 cycles.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 4'h3;
    req1_valid = 1'b1; req1_data = 4'h8;
    ng = 0; nr = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if ((r0r_a || r1r_a) && ng < 8) begin
        g_idx[ng] = r1r_a ? 1 : 0; g_cyc[ng] = c; ng++;
      end
      if (rv_a && nr < 8) begin
        r_id[nr] = rid_a; r_p[nr] = rp_a; r_d[nr] = rd_a; nr++;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("s2_ngrants", ng, 5);
    chk("s2_nrsp", nr, 4);
    for (int i = 0; i < 4; i++) begin
      chk("s2_grant_idx", g_idx[i], i % 2);
      chk("s2_grant_cycle", g_cyc[i], 3 * i);
      chk("s2_rsp_id", r_id[i], i % 2);
      chk("s2_rsp_p", r_p[i], (i % 2 == 0) ? 1 : 0);
      chk("s2_rsp_d", r_d[i], (i % 2 == 0) ? 0 : 1);
    end
    repeat (3) step();

    // Back-pressure: response held while rsp_ready is low.
    do_reset();
    req1_valid = 1'b1; req1_data = 4'hA;
    @(negedge clk);
    chk("s3_ready1", r1r_a, 1'b1);
    step();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 4'h0;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s3_hold_valid", rv_a, 1'b1);
      chk("s3_hold_id", rid_a, 1'b1);
      chk("s3_hold_p", rp_a, 1'b1);
      chk("s3_hold_d", rd_a, 1'b1);
      chk("s3_hold_ready0", r0r_a, 1'b0);
      chk("s3_hold_ready1", r1r_a, 1'b0);
      step();
    end
    rsp_ready = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    chk("s3_last_valid", rv_a, 1'b1);
    step();
    @(negedge clk);
    chk("s3_retired", rv_a, 1'b0);
    step();

    // Saturation at CNT_W=2 and clear on the evaluate edge.
    do_reset();
    rsp_ready = 1'b1; req0_valid = 1'b1; req0_data = 4'h2;
    repeat (13) step();
    req0_valid = 1'b0;
    step();
    @(negedge clk);
    chk("s4_sat_p2", cp_b, 2'd3);
    chk("s4_sat_d2", cd_b, 2'd3);
    chk("s4_cnt_p8", cp_a, 8'd5);
    chk("s4_cnt_d8", cd_a, 8'd5);
    step();
    req0_valid = 1'b1;
    @(negedge clk);
    chk("s4_ready0", r0r_a, 1'b1);
    step();
    req0_valid = 1'b0; clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("s4_clr_p8", cp_a, 8'd0);
    chk("s4_clr_d8", cd_a, 8'd0);
    chk("s4_clr_p2", cp_b, 2'd0);
    chk("s4_clr_d2", cd_b, 2'd0);
    chk("s4_clr_rsp", rv_a, 1'b1);
    step();

    // Reset while a response is held, then normal service on requester 1.
    do_reset();
    req0_valid = 1'b1; req0_data = 4'h5;
    step();
    req0_valid = 1'b0;
    step();
    @(negedge clk);
    chk("s5_held", rv_a, 1'b1);
    chk("s5_cnt_before", cp_a, 8'd1);
    step();
    rst_n = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    chk("s5_rst_ready0", r0r_a, 1'b0);
    chk("s5_rst_ready1", r1r_a, 1'b0);
    step();
    rst_n = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    chk("s5_rsp_cleared", rv_a, 1'b0);
    chk("s5_qd_a_cleared", qd_a_a, 4'h0);
    chk("s5_cnt_p_cleared", cp_a, 8'd0);
    chk("s5_cnt_d_cleared", cd_a, 8'd0);
    step();
    req1_valid = 1'b1; req1_data = 4'h8; rsp_ready = 1'b1;
    @(negedge clk);
    chk("s5_ready1", r1r_a, 1'b1);
    step();
    req1_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rv_a) begin
        found = 1'b1;
        chk("s5_rsp_id", rid_a, 1'b1);
        chk("s5_rsp_p", rp_a, 1'b0);
        chk("s5_rsp_d", rd_a, 1'b1);
      end
      step();
    end
    chk("s5_rsp_seen", found, 1'b1);

    // Reset during evaluate aborts the request without counting it.
    do_reset();
    rsp_ready = 1'b1; req0_valid = 1'b1; req0_data = 4'h5;
    step();
    req0_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s6_no_rsp", rv_a, 1'b0);
      chk("s6_no_cnt", cp_a, 8'd0);
      step();
    end

    // Code with neither property set.
    do_reset();
    rsp_ready = 1'b1; req0_valid = 1'b1; req0_data = 4'hF;
    step();
    req0_valid = 1'b0;
    step();
    @(negedge clk);
    chk("s7_rsp_valid", rv_a, 1'b1);
    chk("s7_rsp_p", rp_a, 1'b0);
    chk("s7_rsp_d", rd_a, 1'b0);
    chk("s7_cnt_p", cp_a, 8'd0);
    chk("s7_cnt_d", cd_a, 8'd0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
